// File: rtl/fir_ctrl_pkg.sv
// Shared types and widths for the FIR equalizer configuration path.
package fir_ctrl_pkg;

  localparam int COEF_W = 16;
  localparam int TAP_W  = 8;
  localparam int SEL_W  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE_CHK,
    ST_PRE_PAD,
    ST_GET_LSB,
    ST_GET_MSB,
    ST_WRITE,
    ST_POST_CHK,
    ST_POST_PAD,
    ST_RESUME
  } loader_state_t;

endpackage

// File: rtl/fir_coef_loader.sv
// Coefficient load sequencer: assembles host bytes into 16-bit coefficients, keeps the
// bank write address aligned to zero around each load and gates audio while loading.
module fir_coef_loader
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_FILTERS  = 4,
  parameter int BYTE_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] filter_sel,
  input  logic [TAP_W-1:0] taps_per_filter,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic             wr_addr_zero,
  input  logic             sample_strobe,
  input  logic             audio_en_in,
  output logic             audio_en,
  output logic             coefficient_wr_en,
  output logic [SEL_W-1:0] coef_select,
  output logic [7:0]       coef_wr_lsb_data,
  output logic [7:0]       coef_wr_msb_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IDLE_W = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] TIMEOUT_LIM = IDLE_W'(BYTE_TIMEOUT);
  localparam logic [SEL_W:0]    NUM_FILT_L  = (SEL_W + 1)'(NUM_FILTERS);

  loader_state_t     state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [TAP_W-1:0]  taps_q, taps_d;
  logic [TAP_W-1:0]  tap_cnt_q, tap_cnt_d;
  logic [COEF_W-1:0] coef_q, coef_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              hold_q, hold_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              audio_en_q, audio_en_d;

  logic              get_state;
  logic              xfer;
  logic [IDLE_W-1:0] idle_inc;
  logic              timeout_hit;
  logic              start_ok;

  assign get_state   = (state_q == ST_GET_LSB) || (state_q == ST_GET_MSB);
  assign xfer        = byte_valid && get_state;
  assign idle_inc    = idle_q + 1'b1;
  assign timeout_hit = (BYTE_TIMEOUT != 0) && (idle_inc == TIMEOUT_LIM);
  assign start_ok    = ({1'b0, filter_sel} < NUM_FILT_L) && (taps_per_filter != '0);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    taps_d    = taps_q;
    tap_cnt_d = tap_cnt_q;
    coef_d    = coef_q;
    idle_d    = '0;
    hold_d    = hold_q;
    error_d   = error_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            sel_d     = filter_sel;
            taps_d    = taps_per_filter;
            tap_cnt_d = '0;
            error_d   = 1'b0;
            hold_d    = 1'b1;
            state_d   = ST_PRE_CHK;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ST_PRE_CHK:  state_d = wr_addr_zero ? ST_GET_LSB : ST_PRE_PAD;
      ST_PRE_PAD:  state_d = ST_PRE_CHK;
      ST_GET_LSB, ST_GET_MSB: begin
        if (xfer) begin
          if (state_q == ST_GET_LSB) begin
            coef_d[7:0] = byte_data;
            state_d     = ST_GET_MSB;
          end else begin
            coef_d[COEF_W-1:8] = byte_data;
            state_d            = ST_WRITE;
          end
        end else if (BYTE_TIMEOUT != 0) begin
          idle_d = idle_inc;
          // A stalled host abandons the load but still realigns the bank address.
          if (timeout_hit) begin
            error_d = 1'b1;
            state_d = ST_POST_CHK;
          end
        end
      end
      ST_WRITE: begin
        tap_cnt_d = tap_cnt_q + 1'b1;
        state_d   = (tap_cnt_q == taps_q - 1'b1) ? ST_POST_CHK : ST_GET_LSB;
      end
      ST_POST_CHK: state_d = wr_addr_zero ? ST_RESUME : ST_POST_PAD;
      ST_POST_PAD: state_d = ST_POST_CHK;
      ST_RESUME: begin
        if (sample_strobe) begin
          hold_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Using the next hold value lets audio_en track hold on the same edge.
  assign audio_en_d = audio_en_in && !hold_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      taps_q     <= '0;
      tap_cnt_q  <= '0;
      coef_q     <= '0;
      idle_q     <= '0;
      hold_q     <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      audio_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      taps_q     <= taps_d;
      tap_cnt_q  <= tap_cnt_d;
      coef_q     <= coef_d;
      idle_q     <= idle_d;
      hold_q     <= hold_d;
      error_q    <= error_d;
      done_q     <= done_d;
      audio_en_q <= audio_en_d;
    end
  end

  assign coefficient_wr_en = (state_q == ST_WRITE) || (state_q == ST_PRE_PAD) ||
                             (state_q == ST_POST_PAD);
  assign coef_wr_lsb_data  = (state_q == ST_WRITE) ? coef_q[7:0] : 8'h00;
  assign coef_wr_msb_data  = (state_q == ST_WRITE) ? coef_q[COEF_W-1:8] : 8'h00;
  assign coef_select       = sel_q;
  assign byte_ready        = get_state;
  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign error             = error_q;
  assign audio_en          = audio_en_q;

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Configuration sequencer for the FIR equalizer filter bank.
- Takes a host byte stream (from the SPI register path) and assembles it into 16-bit coefficients, LSB first.
- Issues coefficient write strobes, filter select and data bytes to the filter bank.
- Keeps the bank's coefficient write-address counter aligned to zero, holds audio_en low during a load, and re-enables audio on a sample boundary.

Parameters:
- NUM_FILTERS, 4, number of coefficient RAMs in the filter bank; valid filter_sel range is 0..NUM_FILTERS-1.
- BYTE_TIMEOUT, 65535, idle cycles allowed between bytes before the load aborts; 0 disables the timeout.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  load request; accepted only in IDLE.
- filter_sel  in  4  target filter, latched on start.
- taps_per_filter  in  8  coefficients per filter, latched on start.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- wr_addr_zero  in  1  filter bank coefficient write address == 0.
- sample_strobe  in  1  per-sample strobe; connect to r_data_en.
- audio_en_in  in  1  global audio enable from the register file.
- audio_en  out  1  gated audio enable to the filter bank.
- coefficient_wr_en  out  1  one-cycle coefficient write strobe.
- coef_select  out  4  filter index for the write.
- coef_wr_lsb_data  out  8  coefficient bits [7:0].
- coef_wr_msb_data  out  8  coefficient bits [15:8].
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at load completion.
- error  out  1  sticky; cleared on the next accepted start.

Behaviour:
- Reset values: all outputs 0, state IDLE, hold=0.
- audio_en is registered: audio_en <= audio_en_in && !hold.
- States: IDLE, PRE_CHK, PRE_PAD, GET_LSB, GET_MSB, WRITE, POST_CHK, POST_PAD, RESUME.
- IDLE:
  - On start with filter_sel < NUM_FILTERS and taps_per_filter != 0: latch sel and taps, clear tap count and error, set hold=1, go to PRE_CHK.
  - On start with an invalid sel or taps==0: error=1, done pulses next cycle, no writes issued, stay IDLE.
- PRE_CHK / POST_CHK: if wr_addr_zero, go to GET_LSB (PRE) or RESUME (POST); otherwise go to the matching *_PAD state.
- PRE_PAD / POST_PAD: coefficient_wr_en=1 with data 0x0000, then return to the matching *_CHK state.
  - The CHK state always follows a write by one cycle, so it sees the updated address.
- GET_LSB / GET_MSB:
  - byte_ready=1; on transfer, capture the LSB or MSB and advance.
  - An idle counter resets on each transfer. When it reaches BYTE_TIMEOUT (if nonzero): error=1, go to POST_CHK.
- WRITE:
  - coefficient_wr_en=1 for exactly this cycle; coef_select and data stable throughout the cycle; byte_ready=0.
  - Increment the tap count; if count == taps-1 go to POST_CHK, else go to GET_LSB.
- RESUME: wait for sample_strobe, then hold=0, done=1 for one cycle, go to IDLE. audio_en rises on the cycle after the strobe (if audio_en_in=1).
- coefficient_wr_en is decoded from the state register. It is high only in WRITE, PRE_PAD and POST_PAD.
- A nominal load gives taps writes plus one pad: the bank address wraps after taps+1 writes.
- busy = (state != IDLE). start is ignored while busy.
- Bytes offered outside GET_* states are not accepted.
- sample_strobe outside RESUME is ignored.
- Reset mid-load: go to IDLE immediately.
  - A partial RAM content is acceptable; the next load's PRE alignment repairs the address.
  - audio_en is 0 for one cycle, then follows audio_en_in.
- Change of audio_en_in during a load: it has no effect until hold clears.

Decomposition:
- Shared package fir_ctrl_pkg:
  - loader_state_t enum.
  - COEF_W=16, TAP_W=8, SEL_W=4.
- No sub-module. The idle timeout counter and tap counter are local.

Test Plan:
- Nominal load: filter_sel=2, taps=4, bytes 34 12 78 56 BC 9A F0 DE (bench model of the bank address counter) -> 4 writes, coef_select=2, data 0x1234/0x5678/0x9ABC/0xDEF0, then one pad 0x0000. The bank address returns to 0. done pulses and audio_en rises on the cycle after the first sample_strobe following the pad.
- Pre-misaligned address: model address=2, taps=4 -> 3 pad writes before the first byte is accepted, then the nominal sequence.
- Invalid start: filter_sel=5 with NUM_FILTERS=4 (or taps=0) -> error=1, one done pulse, zero writes, audio_en unchanged.
- Timeout: BYTE_TIMEOUT=8, stall after 3 bytes -> one write (0x1234), error=1, pads until wr_addr_zero, done after sample_strobe.
- Host throttling: byte_valid toggled randomly, and a second start pulsed while busy -> same writes as the nominal load, start ignored, no extra writes.
- Reset in GET_MSB: assert reset -> busy=0, coefficient_wr_en=0, audio_en=0 next cycle; a subsequent nominal load completes correctly.
